// File: rtl/mc_pkg.sv
// Shared types and encodings for the multi-cycle main control unit.
package mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC_R,
        S_EXEC_I,
        S_MEM_ADDR,
        S_MEM_RD,
        S_MEM_WB,
        S_MEM_WR,
        S_WB_R,
        S_WB_I,
        S_BRANCH,
        S_JUMP
    } state_t;

    // Which rule picks the ALU operation in the current state.
    typedef enum logic [1:0] {
        ALU_CLS_ADD,
        ALU_CLS_SUB,
        ALU_CLS_FUNCT
    } alu_class_t;

    localparam logic [3:0] OP_RTYPE = 4'h0;
    localparam logic [3:0] OP_ADDI  = 4'h1;
    localparam logic [3:0] OP_LW    = 4'h2;
    localparam logic [3:0] OP_SW    = 4'h3;
    localparam logic [3:0] OP_BEQ   = 4'h4;
    localparam logic [3:0] OP_BLT   = 4'h5;
    localparam logic [3:0] OP_BGT   = 4'h6;
    localparam logic [3:0] OP_J     = 4'h7;

    localparam logic [2:0] FUNCT_ILLEGAL = 3'b111;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_AND = 4'b0010;
    localparam logic [3:0] ALU_OR  = 4'b0011;
    localparam logic [3:0] ALU_XOR = 4'b0100;
    localparam logic [3:0] ALU_NOR = 4'b0101;
    localparam logic [3:0] ALU_SLT = 4'b0110;

    localparam logic [1:0] PC_SRC_ALU    = 2'b00;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

    localparam logic [1:0] ALUB_REG = 2'b00;
    localparam logic [1:0] ALUB_ONE = 2'b01;
    localparam logic [1:0] ALUB_IMM = 2'b10;

endpackage

// File: rtl/mc_alu_dec.sv
// ALU operation decoder: turns the state's ALU class plus opcode/funct into
// the 4-bit ALU op, and flags the unsupported R-type funct.
module mc_alu_dec
    import mc_pkg::*;
(
    input  alu_class_t  alu_class,
    input  logic [3:0]  opcode,
    input  logic [2:0]  funct,
    output logic [3:0]  aluoperation,
    output logic        funct_illegal
);

    assign funct_illegal = (opcode == OP_RTYPE) && (funct == FUNCT_ILLEGAL);

    // R-type funct 0-6 lines up directly with the ALU op encoding.
    always_comb begin
        aluoperation = ALU_ADD;
        case (alu_class)
            ALU_CLS_SUB:   aluoperation = ALU_SUB;
            ALU_CLS_FUNCT: if (!funct_illegal) aluoperation = {1'b0, funct};
            default:       aluoperation = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mc_control.sv
// Multi-cycle main control FSM for the 16-bit MIPS-style datapath.
// Define MC_CTRL_BLT_BGT_EN to enable the BLT/BGT branch opcodes.
module mc_control
    import mc_pkg::*;
#(
    parameter state_t RESET_STATE = S_FETCH
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  opcode,
    input  logic [2:0]  funct,
    input  logic        zero,
    input  logic        lt,
    input  logic        gt,
    input  logic        mem_ready,
    output logic        pc_write,
    output logic [1:0]  pc_src,
    output logic        iord,
    output logic        mem_read,
    output logic        mem_write,
    output logic        ir_write,
    output logic        reg_dst,
    output logic        mem_to_reg,
    output logic        reg_write,
    output logic        alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [3:0]  aluoperation,
    output logic        illegal
);

    state_t     state;
    alu_class_t alu_class;
    logic [3:0] dec_op;
    logic       funct_illegal;
    logic       op_illegal;
    logic       decode_illegal;
    logic       branch_taken;

    mc_alu_dec u_alu_dec (
        .alu_class     (alu_class),
        .opcode        (opcode),
        .funct         (funct),
        .aluoperation  (dec_op),
        .funct_illegal (funct_illegal)
    );

    always_comb begin
        op_illegal = 1'b1;
        case (opcode)
            OP_RTYPE, OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_J: op_illegal = 1'b0;
`ifdef MC_CTRL_BLT_BGT_EN
            OP_BLT, OP_BGT: op_illegal = 1'b0;
`endif
            default: op_illegal = 1'b1;
        endcase
    end

    assign decode_illegal = op_illegal | funct_illegal;

    always_comb begin
        branch_taken = 1'b0;
        case (opcode)
            OP_BEQ: branch_taken = zero;
`ifdef MC_CTRL_BLT_BGT_EN
            OP_BLT: branch_taken = lt;
            OP_BGT: branch_taken = gt;
`endif
            default: branch_taken = 1'b0;
        endcase
    end

`ifndef MC_CTRL_BLT_BGT_EN
    logic unused_flags;
    assign unused_flags = lt ^ gt;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RESET_STATE;
        end else begin
            case (state)
                S_FETCH:    if (mem_ready) state <= S_DECODE;
                S_DECODE: begin
                    if (decode_illegal) begin
                        state <= S_FETCH;
                    end else begin
                        case (opcode)
                            OP_RTYPE:                state <= S_EXEC_R;
                            OP_ADDI:                 state <= S_EXEC_I;
                            OP_LW, OP_SW:            state <= S_MEM_ADDR;
                            OP_BEQ, OP_BLT, OP_BGT:  state <= S_BRANCH;
                            OP_J:                    state <= S_JUMP;
                            default:                 state <= S_FETCH;
                        endcase
                    end
                end
                S_EXEC_R:   state <= S_WB_R;
                S_EXEC_I:   state <= S_WB_I;
                S_MEM_ADDR: state <= (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
                S_MEM_RD:   if (mem_ready) state <= S_MEM_WB;
                S_MEM_WR:   if (mem_ready) state <= S_FETCH;
                default:    state <= S_FETCH;
            endcase
        end
    end

    // Control word decode; reset overrides everything so an in-flight access is dropped.
    always_comb begin
        pc_write   = 1'b0;
        pc_src     = PC_SRC_ALU;
        iord       = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = ALUB_REG;
        alu_class  = ALU_CLS_ADD;
        illegal    = 1'b0;
        case (state)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = ALUB_ONE;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            S_DECODE: begin
                alu_src_b = ALUB_IMM;
                illegal   = decode_illegal;
            end
            S_EXEC_R: begin
                alu_src_a = 1'b1;
                alu_class = ALU_CLS_FUNCT;
            end
            S_EXEC_I, S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = ALUB_IMM;
            end
            S_WB_R: begin
                reg_dst   = 1'b1;
                reg_write = 1'b1;
            end
            S_WB_I:     reg_write = 1'b1;
            S_MEM_RD: begin
                iord     = 1'b1;
                mem_read = 1'b1;
            end
            S_MEM_WB: begin
                mem_to_reg = 1'b1;
                reg_write  = 1'b1;
            end
            S_MEM_WR: begin
                iord      = 1'b1;
                mem_write = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a = 1'b1;
                alu_class = ALU_CLS_SUB;
                pc_src    = PC_SRC_ALUOUT;
                pc_write  = branch_taken;
            end
            S_JUMP: begin
                pc_src   = PC_SRC_JUMP;
                pc_write = 1'b1;
            end
            default: ;
        endcase
        if (rst) begin
            pc_write   = 1'b0;
            pc_src     = PC_SRC_ALU;
            iord       = 1'b0;
            mem_read   = 1'b0;
            mem_write  = 1'b0;
            ir_write   = 1'b0;
            reg_dst    = 1'b0;
            mem_to_reg = 1'b0;
            reg_write  = 1'b0;
            alu_src_a  = 1'b0;
            alu_src_b  = ALUB_REG;
            illegal    = 1'b0;
        end
    end

    assign aluoperation = rst ? ALU_ADD : dec_op;

endmodule

// File: tb/tb_mc_control.sv
// Self-checking bench for mc_control: per-instruction expected control words
// are built from the instruction class, stall counts and flag values.
module tb_mc_control;

    logic        clk;
    logic        rst;
    logic [3:0]  opcode;
    logic [2:0]  funct;
    logic        zero, lt, gt;
    logic        mem_ready;
    logic        pc_write;
    logic [1:0]  pc_src;
    logic        iord, mem_read, mem_write, ir_write;
    logic        reg_dst, mem_to_reg, reg_write, alu_src_a;
    logic [1:0]  alu_src_b;
    logic [3:0]  aluoperation;
    logic        illegal;

    int checks = 0;
    int passed = 0;

    mc_control dut (
        .clk          (clk),
        .rst          (rst),
        .opcode       (opcode),
        .funct        (funct),
        .zero         (zero),
        .lt           (lt),
        .gt           (gt),
        .mem_ready    (mem_ready),
        .pc_write     (pc_write),
        .pc_src       (pc_src),
        .iord         (iord),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .ir_write     (ir_write),
        .reg_dst      (reg_dst),
        .mem_to_reg   (mem_to_reg),
        .reg_write    (reg_write),
        .alu_src_a    (alu_src_a),
        .alu_src_b    (alu_src_b),
        .aluoperation (aluoperation),
        .illegal      (illegal)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    logic [17:0] obs_word;
    assign obs_word = {pc_write, pc_src, iord, mem_read, mem_write, ir_write,
                       reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b,
                       aluoperation, illegal};

    // Packs one cycle's expected control outputs in the same order as obs_word.
    function automatic logic [17:0] make_word(
        input logic pcw, input logic [1:0] pcs, input logic io, input logic mr,
        input logic mw, input logic irw, input logic rd, input logic m2r,
        input logic rw, input logic asa, input logic [1:0] asb,
        input logic [3:0] op, input logic ill);
        return {pcw, pcs, io, mr, mw, irw, rd, m2r, rw, asa, asb, op, ill};
    endfunction

    function automatic bit isIllegal(input logic [3:0] op, input logic [2:0] fn);
        if (op > 4'd7) return 1'b1;
        if (op == 4'd0 && fn == 3'd7) return 1'b1;
`ifndef MC_CTRL_BLT_BGT_EN
        if (op == 4'd5 || op == 4'd6) return 1'b1;
`endif
        return 1'b0;
    endfunction

    task automatic checkOutput(input string tag, input logic [17:0] obs, input logic [17:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Runs one instruction from its first fetch cycle to its last cycle.
    // f = fetch wait cycles, m = memory wait cycles; flags held for the whole instruction.
    task automatic applyStimulus(input logic [3:0] op, input logic [2:0] fn,
                                 input int f, input int m,
                                 input logic z, input logic l, input logic g);
        logic [17:0] exp_q[$];
        logic        mr_q[$];
        logic        taken;
        bit          ill;
        ill = isIllegal(op, fn);
        for (int i = 0; i < f; i++) begin
            exp_q.push_back(make_word(0, 2'b00, 0, 1, 0, 0, 0, 0, 0, 0, 2'b01, 4'h0, 0));
            mr_q.push_back(1'b0);
        end
        exp_q.push_back(make_word(1, 2'b00, 0, 1, 0, 1, 0, 0, 0, 0, 2'b01, 4'h0, 0));
        mr_q.push_back(1'b1);
        exp_q.push_back(make_word(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 2'b10, 4'h0, ill));
        mr_q.push_back(1'($urandom_range(0, 1)));
        if (!ill) begin
            case (op)
                4'd0: begin
                    exp_q.push_back(make_word(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, {1'b0, fn}, 0));
                    exp_q.push_back(make_word(0, 2'b00, 0, 0, 0, 0, 1, 0, 1, 0, 2'b00, 4'h0, 0));
                end
                4'd1: begin
                    exp_q.push_back(make_word(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 4'h0, 0));
                    exp_q.push_back(make_word(0, 2'b00, 0, 0, 0, 0, 0, 0, 1, 0, 2'b00, 4'h0, 0));
                end
                4'd2, 4'd3: begin
                    exp_q.push_back(make_word(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 4'h0, 0));
                    mr_q.push_back(1'($urandom_range(0, 1)));
                    for (int i = 0; i <= m; i++) begin
                        if (op == 4'd2)
                            exp_q.push_back(make_word(0, 2'b00, 1, 1, 0, 0, 0, 0, 0, 0, 2'b00, 4'h0, 0));
                        else
                            exp_q.push_back(make_word(0, 2'b00, 1, 0, 1, 0, 0, 0, 0, 0, 2'b00, 4'h0, 0));
                        mr_q.push_back(i == m);
                    end
                    if (op == 4'd2)
                        exp_q.push_back(make_word(0, 2'b00, 0, 0, 0, 0, 0, 1, 1, 0, 2'b00, 4'h0, 0));
                end
                4'd4, 4'd5, 4'd6: begin
                    taken = (op == 4'd4) ? z : (op == 4'd5) ? l : g;
                    exp_q.push_back(make_word(taken, 2'b01, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 4'h1, 0));
                end
                default: begin
                    exp_q.push_back(make_word(1, 2'b10, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 4'h0, 0));
                end
            endcase
        end
        while (mr_q.size() < exp_q.size()) mr_q.push_back(1'($urandom_range(0, 1)));
        for (int k = 0; k < exp_q.size(); k++) begin
            opcode    = op;
            funct     = fn;
            zero      = z;
            lt        = l;
            gt        = g;
            mem_ready = mr_q[k];
            @(negedge clk);
            checkOutput($sformatf("op%0h_fn%0d_cyc%0d", op, fn, k), obs_word, exp_q[k]);
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst = 1'b1;
        opcode = 4'd0; funct = 3'd0; zero = 1'b0; lt = 1'b0; gt = 1'b0;
        mem_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        checkOutput("reset_hold", obs_word, 18'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Directed cases from the instruction classes and boundary conditions.
        applyStimulus(4'd0, 3'd0, 0, 0, 0, 0, 0);
        applyStimulus(4'd2, 3'd3, 0, 2, 0, 0, 0);
        applyStimulus(4'd4, 3'd0, 0, 0, 1, 0, 0);
        applyStimulus(4'd4, 3'd0, 0, 0, 0, 1, 1);
        applyStimulus(4'd6, 3'd0, 0, 0, 0, 0, 1);
        applyStimulus(4'd5, 3'd0, 1, 0, 0, 1, 0);
        applyStimulus(4'hF, 3'd0, 0, 0, 0, 0, 0);
        applyStimulus(4'd0, 3'd7, 0, 0, 0, 0, 0);
        applyStimulus(4'd1, 3'd2, 2, 0, 0, 0, 0);
        applyStimulus(4'd3, 3'd1, 1, 3, 0, 0, 0);
        applyStimulus(4'd7, 3'd5, 0, 0, 0, 0, 0);
        applyStimulus(4'd0, 3'd6, 0, 0, 0, 0, 0);

        // Reset while a store is waiting on memory.
        opcode = 4'd3; funct = 3'd0; mem_ready = 1'b1;
        @(posedge clk); #1;
        mem_ready = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        checkOutput("store_wait", obs_word,
                    make_word(0, 2'b00, 1, 0, 1, 0, 0, 0, 0, 0, 2'b00, 4'h0, 0));
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        checkOutput("reset_mid_store", obs_word, 18'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("fetch_after_reset", obs_word,
                    make_word(0, 2'b00, 0, 1, 0, 0, 0, 0, 0, 0, 2'b01, 4'h0, 0));
        @(posedge clk); #1;

        for (int n = 0; n < 80; n++) begin
            applyStimulus(4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)),
                          int'($urandom_range(0, 2)), int'($urandom_range(0, 3)),
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
